// File: rtl/uart_pkg.sv
// uart_pkg: shared IIR codes, IER bit indices and timer sizing for the UART interrupt logic
package uart_pkg;
  typedef enum logic [3:0] {
    NONE = 4'b0001,
    RLS  = 4'b0110,
    RDA  = 4'b0100,
    CTI  = 4'b1100,
    THRE = 4'b0010,
    MS   = 4'b0000
  } iir_id_t;
  localparam int IER_ERBI  = 0;
  localparam int IER_ETBEI = 1;
  localparam int IER_ELSI  = 2;
  localparam int IER_EDSSI = 3;
  localparam int CHAR_BITS_MAX = 12;
  function automatic int tmr_w(input int tout_chars, input int baud_per_bit);
    return $clog2(tout_chars * CHAR_BITS_MAX * baud_per_bit + 1);
  endfunction
endpackage

// File: rtl/uart_char_timer.sv
// uart_char_timer: RX idle counter that flags a character timeout after TOUT_CHARS frame times
import uart_pkg::*;
module uart_char_timer #(
  parameter int BAUD_PER_BIT = 16,
  parameter int TOUT_CHARS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       fifo_en,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       stb,
  input  logic       rx_push,
  input  logic       rx_pop,
  input  logic       rx_fifo_empty,
  output logic       tout_hit
);
  localparam int W = tmr_w(TOUT_CHARS, BAUD_PER_BIT);
  logic [3:0] char_bits;
  logic [W-1:0] limit, cnt_q, cnt_d;
  logic clr;
  always_comb begin
    char_bits = 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
    limit = W'(TOUT_CHARS * BAUD_PER_BIT) * W'(char_bits);
    clr = rx_push | rx_pop | rx_fifo_empty | !fifo_en;
    cnt_d = clr ? '0 : (baud_pulse && cnt_q < limit) ? cnt_q + 1'b1 : cnt_q;
    tout_hit = !clr && cnt_d >= limit;
  end
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: prioritized 16550 interrupt/IIR generation; UART_MSI_EN enables the modem-status source
import uart_pkg::*;
module uart_irq_ctrl #(
  parameter int BAUD_PER_BIT = 16,
  parameter int TOUT_CHARS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [3:0] ier,
  input  logic       fifo_en,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       stb,
  input  logic       rx_fifo_empty,
  input  logic       rx_trig,
  input  logic       rx_push,
  input  logic       rx_pop,
  input  logic       lsr_err,
  input  logic       lsr_rd,
  input  logic       tx_fifo_empty,
  input  logic       thr_wr,
  input  logic       iir_rd,
  input  logic       msr_delta,
  input  logic       msr_rd,
  output logic       intr,
  output logic [7:0] iir
);
  logic ls_pend_q, ls_pend_d, cti_pend_q, cti_pend_d, thre_pend_q, thre_pend_d, ms_pend_q, ms_pend_d;
  logic txe_q, ier1_q, intr_q, intr_d, rda, thre_set, tout_hit;
  logic [7:0] iir_q, iir_d;
  iir_id_t id;
  uart_char_timer #(.BAUD_PER_BIT(BAUD_PER_BIT), .TOUT_CHARS(TOUT_CHARS)) u_tmr (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .fifo_en(fifo_en), .wls(wls), .pen(pen),
    .stb(stb), .rx_push(rx_push), .rx_pop(rx_pop), .rx_fifo_empty(rx_fifo_empty), .tout_hit(tout_hit)
  );
`ifdef UART_MSI_EN
  assign ms_pend_d = msr_delta | (ms_pend_q & !msr_rd);
`else
  logic unused_ms;
  assign unused_ms = msr_delta ^ msr_rd;
  assign ms_pend_d = 1'b0;
`endif
  always_comb begin
    ls_pend_d = lsr_err | (ls_pend_q & !lsr_rd);
    rda = fifo_en ? rx_trig : !rx_fifo_empty;
    cti_pend_d = fifo_en & !rx_pop & !rx_push & (tout_hit | cti_pend_q);
    thre_set = tx_fifo_empty & (!txe_q | (ier[IER_ETBEI] & !ier1_q));
    thre_pend_d = !thr_wr & (thre_set | (thre_pend_q & !(iir_rd && iir_q[3:0] == THRE)));
    id = (ls_pend_q & ier[IER_ELSI]) ? RLS :
         (rda & ier[IER_ERBI]) ? RDA :
         (cti_pend_q & ier[IER_ERBI]) ? CTI :
         (thre_pend_q & ier[IER_ETBEI]) ? THRE :
         (ms_pend_q & ier[IER_EDSSI]) ? MS : NONE;
    iir_d = {fifo_en ? 2'b11 : 2'b00, 2'b00, id};
    intr_d = !iir_d[0];
  end
  always_ff @(posedge clk) begin
    ls_pend_q   <= rst ? 1'b0 : ls_pend_d;
    cti_pend_q  <= rst ? 1'b0 : cti_pend_d;
    thre_pend_q <= rst ? 1'b0 : thre_pend_d;
    ms_pend_q   <= rst ? 1'b0 : ms_pend_d;
    txe_q       <= rst ? 1'b1 : tx_fifo_empty;
    ier1_q      <= rst ? 1'b0 : ier[IER_ETBEI];
    iir_q       <= rst ? 8'h01 : iir_d;
    intr_q      <= rst ? 1'b0 : intr_d;
  end
  assign iir = iir_q;
  assign intr = intr_q;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl: directed checks of interrupt priority, THRE/CTI/MS behaviour and reset
module tb_uart_irq_ctrl;
  logic clk = 1'b0, rst, baud_pulse, fifo_en, pen, stb, rx_fifo_empty, rx_trig, rx_push, rx_pop;
  logic lsr_err, lsr_rd, tx_fifo_empty, thr_wr, iir_rd, msr_delta, msr_rd, intr;
  logic [3:0] ier;
  logic [1:0] wls;
  logic [7:0] iir;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  uart_irq_ctrl dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .ier(ier), .fifo_en(fifo_en), .wls(wls),
    .pen(pen), .stb(stb), .rx_fifo_empty(rx_fifo_empty), .rx_trig(rx_trig), .rx_push(rx_push),
    .rx_pop(rx_pop), .lsr_err(lsr_err), .lsr_rd(lsr_rd), .tx_fifo_empty(tx_fifo_empty),
    .thr_wr(thr_wr), .iir_rd(iir_rd), .msr_delta(msr_delta), .msr_rd(msr_rd), .intr(intr), .iir(iir)
  );
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    {baud_pulse, fifo_en, pen, stb, rx_trig, rx_push, rx_pop, lsr_err, lsr_rd} = '0;
    {tx_fifo_empty, thr_wr, iir_rd, msr_delta, msr_rd} = '0;
    rx_fifo_empty = 1'b1;
    ier = 4'h0;
    wls = 2'b00;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (iir !== 8'h01) begin failures++; $display("FAIL reset_iir got=%h exp=01", iir); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_intr got=%b exp=0", intr); end
    tx_fifo_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (iir !== 8'h01 || intr !== 1'b0) begin failures++; $display("FAIL masked_thre cyc=%0d iir=%h intr=%b exp=01/0", i, iir, intr); end
    end
  endtask
  task automatic test_thre();
    do_reset();
    fifo_en = 1'b1;
    ier = 4'h2;
    step(2);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL thre_idle got=%h exp=c1", iir); end
    tx_fifo_empty = 1'b1;
    step(1);
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL thre_lat1 intr=%b exp=0", intr); end
    step(1);
    checks++; if (intr !== 1'b1 || iir !== 8'hC2) begin failures++; $display("FAIL thre_set intr=%b iir=%h exp=1/c2", intr, iir); end
    iir_rd = 1'b1;
    step(1);
    iir_rd = 1'b0;
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL thre_rd_lat intr=%b exp=1", intr); end
    step(1);
    checks++; if (intr !== 1'b0 || iir !== 8'hC1) begin failures++; $display("FAIL thre_rd_clr intr=%b iir=%h exp=0/c1", intr, iir); end
    iir_rd = 1'b1;
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL thre_rd2 got=%h exp=c1", iir); end
    step(1);
    iir_rd = 1'b0;
    step(2);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL thre_rd2_after got=%h exp=c1", iir); end
    ier = 4'h0;
    step(2);
    ier = 4'h2;
    step(2);
    checks++; if (iir !== 8'hC2) begin failures++; $display("FAIL thre_ier_rise got=%h exp=c2", iir); end
    thr_wr = 1'b1;
    step(1);
    thr_wr = 1'b0;
    step(1);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL thre_thr_wr got=%h exp=c1", iir); end
  endtask
  task automatic test_priority();
    do_reset();
    fifo_en = 1'b1;
    ier = 4'hF;
    rx_fifo_empty = 1'b0;
    lsr_err = 1'b1;
    rx_trig = 1'b1;
    step(1);
    lsr_err = 1'b0;
    step(1);
    checks++; if (iir[3:0] !== 4'b0110) begin failures++; $display("FAIL prio_rls got=%b exp=0110", iir[3:0]); end
    lsr_rd = 1'b1;
    step(1);
    lsr_rd = 1'b0;
    step(1);
    checks++; if (iir[3:0] !== 4'b0100) begin failures++; $display("FAIL prio_rda got=%b exp=0100", iir[3:0]); end
    rx_pop = 1'b1;
    rx_trig = 1'b0;
    step(1);
    rx_pop = 1'b0;
    step(1);
    checks++; if (iir !== 8'hC1 || intr !== 1'b0) begin failures++; $display("FAIL prio_none iir=%h intr=%b exp=c1/0", iir, intr); end
    ier = 4'h4;
    lsr_err = 1'b1;
    lsr_rd = 1'b1;
    step(1);
    lsr_err = 1'b0;
    lsr_rd = 1'b0;
    step(1);
    checks++; if (iir !== 8'hC6) begin failures++; $display("FAIL ls_set_wins got=%h exp=c6", iir); end
  endtask
  task automatic test_cti();
    do_reset();
    fifo_en = 1'b1;
    ier = 4'h1;
    wls = 2'b11;
    rx_fifo_empty = 1'b0;
    rx_push = 1'b1;
    step(1);
    rx_push = 1'b0;
    baud_pulse = 1'b1;
    step(639);
    baud_pulse = 1'b0;
    step(3);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL cti_639 got=%h exp=c1", iir); end
    baud_pulse = 1'b1;
    step(1);
    baud_pulse = 1'b0;
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL cti_640_lat got=%h exp=c1", iir); end
    step(1);
    checks++; if (iir !== 8'hCC || intr !== 1'b1) begin failures++; $display("FAIL cti_640 iir=%h intr=%b exp=cc/1", iir, intr); end
    rx_push = 1'b1;
    step(1);
    rx_push = 1'b0;
    step(1);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL cti_push_clr got=%h exp=c1", iir); end
    baud_pulse = 1'b1;
    step(639);
    rx_push = 1'b1;
    step(1);
    rx_push = 1'b0;
    step(639);
    baud_pulse = 1'b0;
    step(2);
    checks++; if (iir !== 8'hC1) begin failures++; $display("FAIL cti_restart got=%h exp=c1", iir); end
    baud_pulse = 1'b1;
    step(1);
    baud_pulse = 1'b0;
    step(1);
    checks++; if (iir !== 8'hCC) begin failures++; $display("FAIL cti_restart_hit got=%h exp=cc", iir); end
  endtask
  task automatic test_ms();
    logic [7:0] exp_set;
    logic exp_intr;
`ifdef UART_MSI_EN
    exp_set = 8'h00;
    exp_intr = 1'b1;
`else
    exp_set = 8'h01;
    exp_intr = 1'b0;
`endif
    do_reset();
    ier = 4'h8;
    msr_delta = 1'b1;
    step(1);
    msr_delta = 1'b0;
    step(1);
    checks++; if (iir !== exp_set || intr !== exp_intr) begin failures++; $display("FAIL ms_set iir=%h intr=%b exp=%h/%b", iir, intr, exp_set, exp_intr); end
    msr_rd = 1'b1;
    step(1);
    msr_rd = 1'b0;
    step(1);
    checks++; if (iir !== 8'h01 || intr !== 1'b0) begin failures++; $display("FAIL ms_clr iir=%h intr=%b exp=01/0", iir, intr); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    fifo_en = 1'b1;
    ier = 4'h3;
    rx_fifo_empty = 1'b0;
    rx_push = 1'b1;
    step(1);
    rx_push = 1'b0;
    baud_pulse = 1'b1;
    step(640);
    baud_pulse = 1'b0;
    tx_fifo_empty = 1'b1;
    step(3);
    checks++; if (iir !== 8'hCC) begin failures++; $display("FAIL rst_pre got=%h exp=cc", iir); end
    rst = 1'b1;
    step(1);
    checks++; if (iir !== 8'h01 || intr !== 1'b0) begin failures++; $display("FAIL rst_mid iir=%h intr=%b exp=01/0", iir, intr); end
    step(1);
    checks++; if (iir !== 8'h01 || intr !== 1'b0) begin failures++; $display("FAIL rst_hold iir=%h intr=%b exp=01/0", iir, intr); end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_thre();
    test_priority();
    test_cti();
    test_ms();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
